// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding definitions for the instruction encoder/loader: mnemonic codes,
// the 6-bit opcodes the ID-stage decoder expects, field positions and word packers.
package instr_encoder_loader_pkg;

    localparam int MNEM_W = 5;
    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;

    localparam logic [MNEM_W-1:0] MN_NOP  = 5'd0;
    localparam logic [MNEM_W-1:0] MN_ADD  = 5'd1;
    localparam logic [MNEM_W-1:0] MN_SUB  = 5'd2;
    localparam logic [MNEM_W-1:0] MN_AND  = 5'd3;
    localparam logic [MNEM_W-1:0] MN_OR   = 5'd4;
    localparam logic [MNEM_W-1:0] MN_NOR  = 5'd5;
    localparam logic [MNEM_W-1:0] MN_XOR  = 5'd6;
    localparam logic [MNEM_W-1:0] MN_SLA  = 5'd7;
    localparam logic [MNEM_W-1:0] MN_SLL  = 5'd8;
    localparam logic [MNEM_W-1:0] MN_SRA  = 5'd9;
    localparam logic [MNEM_W-1:0] MN_SRL  = 5'd10;
    localparam logic [MNEM_W-1:0] MN_ADDI = 5'd11;
    localparam logic [MNEM_W-1:0] MN_SUBI = 5'd12;
    localparam logic [MNEM_W-1:0] MN_LD   = 5'd13;
    localparam logic [MNEM_W-1:0] MN_ST   = 5'd14;
    localparam logic [MNEM_W-1:0] MN_BEZ  = 5'd15;
    localparam logic [MNEM_W-1:0] MN_BNE  = 5'd16;
    localparam logic [MNEM_W-1:0] MN_JMP  = 5'd17;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000011;
    localparam logic [OP_W-1:0] OP_AND  = 6'b000101;
    localparam logic [OP_W-1:0] OP_OR   = 6'b000110;
    localparam logic [OP_W-1:0] OP_NOR  = 6'b000111;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLA  = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLL  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SRA  = 6'b001011;
    localparam logic [OP_W-1:0] OP_SRL  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUBI = 6'b100001;
    localparam logic [OP_W-1:0] OP_LD   = 6'b100100;
    localparam logic [OP_W-1:0] OP_ST   = 6'b100101;
    localparam logic [OP_W-1:0] OP_BEZ  = 6'b101000;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b101001;
    localparam logic [OP_W-1:0] OP_JMP  = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FULL
    } state_t;

    function automatic logic [WORD_W-1:0] pack_r(input logic [OP_W-1:0] op,
                                                 input logic [REG_W-1:0] rd,
                                                 input logic [REG_W-1:0] rs1,
                                                 input logic [REG_W-1:0] rs2);
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W]   = op;
        w[RD_LSB +: REG_W]  = rd;
        w[RS1_LSB +: REG_W] = rs1;
        w[RS2_LSB +: REG_W] = rs2;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] pack_i(input logic [OP_W-1:0] op,
                                                 input logic [REG_W-1:0] rd,
                                                 input logic [REG_W-1:0] rs1,
                                                 input logic [IMM_W-1:0] imm);
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W]   = op;
        w[RD_LSB +: REG_W]  = rd;
        w[RS1_LSB +: REG_W] = rs1;
        w[0 +: IMM_W]       = imm;
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_instr_pack.sv
// Combinational packer: symbolic mnemonic plus fields to a 32-bit instruction word.
// Fields a format does not use are passed as zero so stray inputs never leak into the word.
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [MNEM_W-1:0] mnem,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [IMM_W-1:0]  imm,
    output logic              legal,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        legal = 1'b1;
        word  = '0;
        unique case (mnem)
            MN_NOP:  word = '0;
            MN_ADD:  word = pack_r(OP_ADD, rd, rs1, rs2);
            MN_SUB:  word = pack_r(OP_SUB, rd, rs1, rs2);
            MN_AND:  word = pack_r(OP_AND, rd, rs1, rs2);
            MN_OR:   word = pack_r(OP_OR,  rd, rs1, rs2);
            MN_NOR:  word = pack_r(OP_NOR, rd, rs1, rs2);
            MN_XOR:  word = pack_r(OP_XOR, rd, rs1, rs2);
            MN_SLA:  word = pack_r(OP_SLA, rd, rs1, rs2);
            MN_SLL:  word = pack_r(OP_SLL, rd, rs1, rs2);
            MN_SRA:  word = pack_r(OP_SRA, rd, rs1, rs2);
            MN_SRL:  word = pack_r(OP_SRL, rd, rs1, rs2);
            MN_ADDI: word = pack_i(OP_ADDI, rd, rs1, imm);
            MN_SUBI: word = pack_i(OP_SUBI, rd, rs1, imm);
            MN_LD:   word = pack_i(OP_LD,   rd, rs1, imm);
            MN_ST:   word = pack_i(OP_ST,   rd, rs1, imm);
            MN_BEZ:  word = pack_i(OP_BEZ,  '0, rs1, imm);
            MN_BNE:  word = pack_i(OP_BNE,  rd, rs1, imm);
            MN_JMP:  word = pack_i(OP_JMP,  '0, '0,  imm);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instructions, encodes them and writes them to
// instruction memory one word at a time, holding each write request until acked.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ADDR_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MNEM_W-1:0]          in_mnem,
    input  logic [REG_W-1:0]           in_rd,
    input  logic [REG_W-1:0]           in_rs1,
    input  logic [REG_W-1:0]           in_rs2,
    input  logic [IMM_W-1:0]           in_imm,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [WORD_W-1:0]          imem_wdata,
    input  logic                       imem_ack,
    output logic                       err_illegal,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state;
    state_t            state_next;
    logic              pack_legal;
    logic [WORD_W-1:0] pack_word;
    logic              take;

    instr_pack u_pack (
        .mnem  (in_mnem),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .legal (pack_legal),
        .word  (pack_word)
    );

    assign in_ready = rst_n && (state == ST_IDLE);
    assign imem_we  = (state == ST_WRITE);
    assign full     = (state == ST_FULL);
    assign take     = (state == ST_IDLE) && in_valid && !clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The ack of the DEPTH-th word moves to FULL; clear overrides every transition.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (in_valid && pack_legal) state_next = ST_WRITE;
            ST_WRITE: if (imem_ack) state_next = (count == CNT_W'(DEPTH - 1)) ? ST_FULL : ST_IDLE;
            ST_FULL:  state_next = ST_FULL;
            default:  state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imem_addr   <= BASE;
            imem_wdata  <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            if (clear) begin
                imem_addr <= BASE;
                count     <= '0;
            end else begin
                if (take) begin
                    if (pack_legal) begin
                        imem_wdata <= pack_word;
                    end else begin
                        err_illegal <= 1'b1;
                    end
                end
                if ((state == ST_WRITE) && imem_ack) begin
                    imem_addr <= imem_addr + ADDR_W'(4);
                    count     <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of encodings with hand-computed words,
// plus hand-written sequences for ack stalls, clear-with-ack and reset mid-write.
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_mnem = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [15:0] in_imm = '0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack = 1'b0;
    logic        err_illegal;
    logic        full;
    logic [2:0]  count;

    int          total = 0;
    int          bad = 0;
    int          exp_count = 0;
    logic [31:0] exp_addr = 32'h0;

    typedef struct {
        string       name;
        logic [4:0]  mnem;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[$];

    instr_encoder_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0),
        .ADDR_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_ack    (imem_ack),
        .err_illegal (err_illegal),
        .full        (full),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [15:0] imm);
        in_valid = 1'b1;
        in_mnem  = m;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        in_mnem  = '0;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_imm   = '0;
    endtask

    // One transfer from IDLE; when the model hits DEPTH, probe FULL and clear it.
    task automatic applyStimulus(input vec_t v);
        checkOutput({v.name, " ready_before"}, 32'(in_ready), 32'd1);
        drive(v.mnem, v.rd, v.rs1, v.rs2, v.imm);
        tick();
        idleInputs();
        if (v.legal) begin
            checkOutput({v.name, " we"}, 32'(imem_we), 32'd1);
            checkOutput({v.name, " wdata"}, imem_wdata, v.word);
            checkOutput({v.name, " addr"}, imem_addr, exp_addr);
            checkOutput({v.name, " ready_busy"}, 32'(in_ready), 32'd0);
            checkOutput({v.name, " no_err"}, 32'(err_illegal), 32'd0);
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            exp_count++;
            exp_addr += 32'd4;
            checkOutput({v.name, " we_drop"}, 32'(imem_we), 32'd0);
            checkOutput({v.name, " count"}, 32'(count), 32'(exp_count));
            checkOutput({v.name, " addr_next"}, imem_addr, exp_addr);
            if (exp_count == DEPTH) begin
                checkOutput("full_set", 32'(full), 32'd1);
                checkOutput("full_ready", 32'(in_ready), 32'd0);
                drive(5'd1, 5'd1, 5'd1, 5'd1, 16'h0);
                tick();
                tick();
                idleInputs();
                checkOutput("full_ignores_valid_we", 32'(imem_we), 32'd0);
                checkOutput("full_ignores_valid_count", 32'(count), 32'(DEPTH));
                clear = 1'b1;
                tick();
                clear = 1'b0;
                exp_count = 0;
                exp_addr  = 32'h0;
                checkOutput("clear_addr", imem_addr, 32'h0);
                checkOutput("clear_count", 32'(count), 32'd0);
                checkOutput("clear_ready", 32'(in_ready), 32'd1);
                checkOutput("clear_full", 32'(full), 32'd0);
            end else begin
                checkOutput({v.name, " ready_after"}, 32'(in_ready), 32'd1);
                checkOutput({v.name, " not_full"}, 32'(full), 32'd0);
            end
        end else begin
            checkOutput({v.name, " err_pulse"}, 32'(err_illegal), 32'd1);
            checkOutput({v.name, " err_no_we"}, 32'(imem_we), 32'd0);
            tick();
            checkOutput({v.name, " err_clears"}, 32'(err_illegal), 32'd0);
            checkOutput({v.name, " err_still_no_we"}, 32'(imem_we), 32'd0);
            checkOutput({v.name, " err_count"}, 32'(count), 32'(exp_count));
        end
    endtask

    initial begin
        vecs.push_back('{"ADD",    5'd1,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b1, 32'h04221800});
        vecs.push_back('{"ADDI",   5'd11, 5'd1,  5'd0,  5'd31, 16'h000A, 1'b1, 32'h8020000A});
        vecs.push_back('{"ST",     5'd14, 5'd5,  5'd0,  5'd0,  16'h0004, 1'b1, 32'h94A00004});
        vecs.push_back('{"ILL20",  5'd20, 5'd1,  5'd1,  5'd1,  16'h1111, 1'b0, 32'h0});
        vecs.push_back('{"JMP",    5'd17, 5'd7,  5'd9,  5'd4,  16'hFFFE, 1'b1, 32'hA800FFFE});
        vecs.push_back('{"SUB",    5'd2,  5'd31, 5'd30, 5'd29, 16'hFFFF, 1'b1, 32'h0FFEE800});
        vecs.push_back('{"BEZ",    5'd15, 5'd3,  5'd4,  5'd7,  16'h0010, 1'b1, 32'hA0040010});
        vecs.push_back('{"BNE",    5'd16, 5'd2,  5'd1,  5'd0,  16'hFFF8, 1'b1, 32'hA441FFF8});
        vecs.push_back('{"NOP",    5'd0,  5'd5,  5'd6,  5'd7,  16'h1234, 1'b1, 32'h00000000});
        vecs.push_back('{"XOR",    5'd6,  5'd0,  5'd31, 5'd1,  16'hABCD, 1'b1, 32'h201F0800});
        vecs.push_back('{"SRA",    5'd9,  5'd10, 5'd11, 5'd12, 16'h0000, 1'b1, 32'h2D4B6000});
        vecs.push_back('{"LD",     5'd13, 5'd8,  5'd9,  5'd5,  16'h8000, 1'b1, 32'h91098000});
        vecs.push_back('{"ILL31",  5'd31, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h0});
        vecs.push_back('{"ILL18",  5'd18, 5'd2,  5'd2,  5'd2,  16'h0002, 1'b0, 32'h0});
        vecs.push_back('{"NOR",    5'd5,  5'd1,  5'd1,  5'd1,  16'h0000, 1'b1, 32'h1C210800});

        tick();
        tick();
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_wdata", imem_wdata, 32'h0);
        checkOutput("rst_err", 32'(err_illegal), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Ack withheld for five cycles: request, address and data must hold.
        drive(5'd1, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        idleInputs();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d_we", i), 32'(imem_we), 32'd1);
            checkOutput($sformatf("stall%0d_addr", i), imem_addr, 32'h0);
            checkOutput($sformatf("stall%0d_wdata", i), imem_wdata, 32'h04221800);
            checkOutput($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        checkOutput("stall_done_we", 32'(imem_we), 32'd0);
        checkOutput("stall_done_count", 32'(count), 32'd1);
        checkOutput("stall_done_addr", imem_addr, 32'h4);

        // clear coincident with ack wins: no increment, pointer back to base.
        drive(5'd2, 5'd1, 5'd1, 5'd1, 16'h0);
        tick();
        idleInputs();
        checkOutput("clrack_we_before", 32'(imem_we), 32'd1);
        checkOutput("clrack_addr_before", imem_addr, 32'h4);
        imem_ack = 1'b1;
        clear    = 1'b1;
        tick();
        imem_ack = 1'b0;
        clear    = 1'b0;
        checkOutput("clrack_we", 32'(imem_we), 32'd0);
        checkOutput("clrack_count", 32'(count), 32'd0);
        checkOutput("clrack_addr", imem_addr, 32'h0);
        checkOutput("clrack_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a write drops the word.
        drive(5'd11, 5'd1, 5'd0, 5'd0, 16'h000A);
        tick();
        idleInputs();
        checkOutput("rstmid_we_before", 32'(imem_we), 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("rstmid_we", 32'(imem_we), 32'd0);
        checkOutput("rstmid_wdata", imem_wdata, 32'h0);
        checkOutput("rstmid_count", 32'(count), 32'd0);
        checkOutput("rstmid_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rstmid_after_we", 32'(imem_we), 32'd0);
        checkOutput("rstmid_after_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
